// File: rtl/round_timer_if.sv
// Control/status bundle between game control and the round timer.
interface round_timer_if #(
  parameter int LED_W = 10
);
  logic             start;
  logic             hold;
  logic             abort;
  logic             running;
  logic [7:0]       remaining;
  logic             sec_tick;
  logic             warn;
  logic             expired;
  logic             flag;
  logic [LED_W-1:0] led;

  modport master (
    output start, hold, abort,
    input  running, remaining, sec_tick, warn, expired, flag, led
  );

  modport slave (
    input  start, hold, abort,
    output running, remaining, sec_tick, warn, expired, flag, led
  );
endinterface

// File: rtl/round_timer.sv
// Round countdown timer: loads ROUND_S on start, counts whole seconds down, flags expiry.
// Define ROUND_TIMER_BAR_EN to show a thermometer bar on led instead of the warning blink.
module round_timer #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int ROUND_S   = 30,
  parameter int WARN_S    = 10,
  parameter int LED_W     = 10,
  parameter int BLINK_DIV = CLK_HZ / 4
) (
  input  logic         clk,
  input  logic         rst,
  round_timer_if.slave bus
);
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DONE} state_t;

  if (ROUND_S < 1 || ROUND_S > 255) begin : g_chk_round
    $error("round_timer: ROUND_S must be in 1..255");
  end
  if (WARN_S >= ROUND_S) begin : g_chk_warn
    $error("round_timer: WARN_S must be below ROUND_S");
  end
  if (BLINK_DIV < 1) begin : g_chk_blink
    $error("round_timer: BLINK_DIV must be at least 1");
  end

  state_t           r_state, w_state;
  logic [PW-1:0]    r_presc, w_presc;
  logic [7:0]       r_rem, w_rem;
  logic             r_tick, w_tick;
  logic             r_exp, w_exp;
  logic             r_flag, w_flag;
  logic             r_warn, w_warn;
  logic [LED_W-1:0] r_led, w_led;
  logic             w_active, w_count, w_wrap, w_running;

  // Counting happens in RUN, and in HOLD on the cycle hold drops.
  assign w_active = (r_state == S_RUN) || (r_state == S_HOLD);
  assign w_count  = w_active && !bus.hold && !bus.start && !bus.abort;
  assign w_wrap   = w_count && (r_presc == PW'(CLK_HZ - 1));

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state;
  end

  always_comb begin
    w_state = r_state;
    if (bus.abort)      w_state = S_IDLE;
    else if (bus.start) w_state = S_RUN;
    else if (w_active) begin
      if (bus.hold)                        w_state = S_HOLD;
      else if (w_wrap && r_rem == 8'd1)    w_state = S_DONE;
      else                                 w_state = S_RUN;
    end
  end

  always_comb begin
    w_presc = r_presc;
    w_rem   = r_rem;
    w_tick  = 1'b0;
    w_exp   = 1'b0;
    w_flag  = r_flag;
    if (bus.abort) begin
      w_presc = '0;
      w_rem   = 8'd0;
      w_flag  = 1'b0;
    end else if (bus.start) begin
      w_presc = '0;
      w_rem   = 8'(ROUND_S);
      w_flag  = 1'b0;
    end else if (w_wrap) begin
      w_presc = '0;
      w_rem   = r_rem - 8'd1;
      w_tick  = 1'b1;
      if (r_rem == 8'd1) begin
        w_exp  = 1'b1;
        w_flag = 1'b1;
      end
    end else if (w_count) begin
      w_presc = r_presc + PW'(1);
    end
    w_running = (w_state == S_RUN) || (w_state == S_HOLD);
    w_warn    = w_running && (w_rem <= 8'(WARN_S));
  end

`ifdef ROUND_TIMER_BAR_EN
  function automatic logic [LED_W-1:0] f_bar(input logic [7:0] rem);
    int lit;
    f_bar = '0;
    lit   = (int'(rem) * LED_W + ROUND_S - 1) / ROUND_S;
    for (int i = 0; i < LED_W; i++) f_bar[i] = (i < lit);
  endfunction

  always_comb begin
    w_led = w_running ? f_bar(w_rem) : '0;
  end
`else
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] r_blink, w_blink;

  // A fresh warn entry lights the bank and restarts the blink phase.
  always_comb begin
    w_led   = r_led;
    w_blink = r_blink;
    if (bus.abort) begin
      w_led = '0;
    end else if (bus.start) begin
      w_led   = '0;
      w_blink = '0;
    end else if (w_state == S_DONE) begin
      w_led = '1;
    end else if (!w_warn) begin
      w_led = '0;
    end else if (!r_warn) begin
      w_led   = '1;
      w_blink = '0;
    end else if (w_count) begin
      if (r_blink == BW'(BLINK_DIV - 1)) begin
        w_led   = ~r_led;
        w_blink = '0;
      end else begin
        w_blink = r_blink + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) r_blink <= '0;
    else      r_blink <= w_blink;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_presc <= '0;
      r_rem   <= 8'd0;
      r_tick  <= 1'b0;
      r_exp   <= 1'b0;
      r_flag  <= 1'b0;
      r_warn  <= 1'b0;
      r_led   <= '0;
    end else begin
      r_presc <= w_presc;
      r_rem   <= w_rem;
      r_tick  <= w_tick;
      r_exp   <= w_exp;
      r_flag  <= w_flag;
      r_warn  <= w_warn;
      r_led   <= w_led;
    end
  end

  assign bus.running   = (r_state == S_RUN) || (r_state == S_HOLD);
  assign bus.remaining = r_rem;
  assign bus.sec_tick  = r_tick;
  assign bus.warn      = r_warn;
  assign bus.expired   = r_exp;
  assign bus.flag      = r_flag;
  assign bus.led       = r_led;
endmodule

// File: tb/tb_round_timer.sv
// Directed bench for round_timer at CLK_HZ=4, ROUND_S=5, WARN_S=2, LED_W=4, BLINK_DIV=2.
module tb_round_timer;
  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  round_timer_if #(.LED_W(4)) bus ();

  round_timer #(
    .CLK_HZ(4), .ROUND_S(5), .WARN_S(2), .LED_W(4), .BLINK_DIV(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // {running, sec_tick, warn, expired, flag, remaining[7:0], led[3:0]}
  logic [16:0] obs, exp_v;
  assign obs = {bus.running, bus.sec_tick, bus.warn, bus.expired, bus.flag,
                bus.remaining, bus.led};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

`ifdef ROUND_TIMER_BAR_EN
  function automatic logic [3:0] bar_led(input logic [7:0] rem);
    case (rem)
      8'd5, 8'd4: return 4'hF;
      8'd3:       return 4'h7;
      8'd2:       return 4'h3;
      8'd1:       return 4'h1;
      default:    return 4'h0;
    endcase
  endfunction
`endif

  // Expected outputs c cycles after an uninterrupted start edge.
  function automatic logic [16:0] full_exp(input int c);
    logic       run, tk, wn, ex, fl;
    logic [7:0] rem;
    logic [3:0] led;
    rem = (c >= 20) ? 8'd0 : 8'(5 - c / 4);
    run = (c < 20);
    tk  = (c > 0) && (c <= 20) && (c % 4 == 0);
    wn  = (c >= 12) && (c < 20);
    ex  = (c == 20);
    fl  = (c >= 20);
`ifdef ROUND_TIMER_BAR_EN
    led = run ? bar_led(rem) : 4'h0;
`else
    if (c < 12)                        led = 4'h0;
    else if (c >= 20)                  led = 4'hF;
    else if (((c - 12) / 2) % 2 == 0)  led = 4'hF;
    else                               led = 4'h0;
`endif
    return {run, tk, wn, ex, fl, rem, led};
  endfunction

  task automatic test_reset();
    rst = 1'b0; bus.start = 1'b1;
    repeat (3) step();
    n_vec++;
    if (obs !== 17'h0) begin
      n_err++; $display("FAIL reset_hold got %h want %h", obs, 17'h0);
    end
    rst = 1'b1; bus.start = 1'b0;
    step();
    n_vec++;
    if (obs !== 17'h0) begin
      n_err++; $display("FAIL reset_release got %h want %h", obs, 17'h0);
    end
    bus.start = 1'b1; step(); bus.start = 1'b0;
    repeat (13) step();
    rst = 1'b0; step(); rst = 1'b1;
    n_vec++;
    if (obs !== 17'h0) begin
      n_err++; $display("FAIL reset_midround got %h want %h", obs, 17'h0);
    end
  endtask

  task automatic test_full_round();
    bus.start = 1'b1; step(); bus.start = 1'b0;
    for (int c = 0; c <= 24; c++) begin
      if (c > 0) step();
      exp_v = full_exp(c);
      n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL full_round c=%0d got %h want %h", c, obs, exp_v);
      end
    end
    bus.start = 1'b1; step(); bus.start = 1'b0;
    exp_v = full_exp(0);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL flag_clear_on_start got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_hold();
    logic [7:0] rem;
    logic [3:0] led;
    bus.start = 1'b1; step(); bus.start = 1'b0;
    for (int c = 0; c <= 15; c++) begin
      if (c > 0) step();
      rem = (c >= 14) ? 8'd4 : 8'd5;
`ifdef ROUND_TIMER_BAR_EN
      led = 4'hF;
`else
      led = 4'h0;
`endif
      exp_v = {1'b1, (c == 14), 1'b0, 1'b0, 1'b0, rem, led};
      n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL hold c=%0d got %h want %h", c, obs, exp_v);
      end
      if (c == 1)  bus.hold = 1'b1;
      if (c == 11) bus.hold = 1'b0;
    end
  endtask

  task automatic test_restart();
    bus.start = 1'b1; step(); bus.start = 1'b0;
    repeat (17) step();
    bus.start = 1'b1; step(); bus.start = 1'b0;
    exp_v = full_exp(0);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL restart_c18 got %h want %h", obs, exp_v);
    end
    repeat (3) step();
    exp_v = full_exp(3);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL restart_follow got %h want %h", obs, exp_v);
    end
    // Restart landing on the terminal tick edge.
    bus.start = 1'b1; step(); bus.start = 1'b0;
    repeat (19) step();
    bus.start = 1'b1; step(); bus.start = 1'b0;
    exp_v = full_exp(0);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL start_on_terminal got %h want %h", obs, exp_v);
    end
    step();
    exp_v = full_exp(1);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL start_on_terminal_next got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_abort();
    repeat (12) step();
    bus.start = 1'b1; bus.abort = 1'b1; step();
    bus.start = 1'b0; bus.abort = 1'b0;
    n_vec++;
    if (obs !== 17'h0) begin
      n_err++; $display("FAIL start_abort got %h want %h", obs, 17'h0);
    end
    bus.start = 1'b1; step(); bus.start = 1'b0;
    repeat (21) step();
    exp_v = full_exp(21);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL done_before_abort got %h want %h", obs, exp_v);
    end
    bus.hold = 1'b1; repeat (2) step();
    exp_v = full_exp(23);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL hold_in_done got %h want %h", obs, exp_v);
    end
    bus.hold = 1'b0;
    bus.abort = 1'b1; step(); bus.abort = 1'b0;
    n_vec++;
    if (obs !== 17'h0) begin
      n_err++; $display("FAIL abort_from_done got %h want %h", obs, 17'h0);
    end
    bus.hold = 1'b1; repeat (3) step(); bus.hold = 1'b0;
    n_vec++;
    if (obs !== 17'h0) begin
      n_err++; $display("FAIL hold_in_idle got %h want %h", obs, 17'h0);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.hold  = 1'b0;
    bus.abort = 1'b0;
    rst       = 1'b0;
    test_reset();
    test_full_round();
    test_hold();
    test_restart();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/round_timer.md
# round_timer

Parametrised round countdown timer for the guessing-game datapath. Loads a configurable round length on `start`, counts whole seconds down from the system clock, and supports hold (pause) and abort. It drives a last-N-seconds warning display on the LED bank and raises a sticky `flag` plus a one-cycle `expired` pulse when the round runs out. Game control logic consumes `flag`/`expired`; the LED bank and seven-segment driver consume `led`/`remaining`.

## Interface
- `CLK_HZ`, 50_000_000: clock cycles per second; prescaler terminal count is `CLK_HZ-1`.
- `ROUND_S`, 30: round length in seconds; legal range 1..255.
- `WARN_S`, 10: warning window in seconds; must be < `ROUND_S`.
- `LED_W`, 10: LED bank width.
- `BLINK_DIV`, `CLK_HZ/4`: cycles between LED toggles in blink mode; must be >= 1.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle pulse; (re)loads and starts a round.
- `hold`  in  1  level; freezes countdown while high.
- `abort`  in  1  one-cycle pulse; returns to IDLE.
- `running`  out  1  high in RUN or HOLD.
- `remaining`  out  8  seconds left in the round.
- `sec_tick`  out  1  one-cycle pulse on each decrement of `remaining`.
- `warn`  out  1  high when `running` and `remaining <= WARN_S`.
- `expired`  out  1  one-cycle pulse on the RUN->DONE transition.
- `flag`  out  1  sticky round-over indication.
- `led`  out  `LED_W`  warning display.

## Operation
- States: IDLE, RUN, HOLD, DONE. Reset (`rst==0` at an edge) forces IDLE; every output goes to 0; prescaler and blink counter go to 0.
- Priority per cycle: reset > abort > start > hold > count.
- `abort` in any state: go to IDLE; `remaining`=0, `flag`=0, `led`=0, prescaler=0.
- `start` in any state: go to RUN; `remaining`=`ROUND_S`, prescaler=0, blink counter=0, `flag`=0. A restart mid-round is legal and produces no `expired`.
- RUN: prescaler increments each cycle. At `CLK_HZ-1` the prescaler wraps to 0, `remaining` decrements, and `sec_tick`=1. If `remaining` was 1, the block goes to DONE with `expired`=1 and `flag`=1 in the same cycle.
- RUN with `hold`=1 (and no start/abort): go to HOLD. Prescaler, blink counter and `led` freeze. No tick occurs in the cycle in which hold is sampled.
- HOLD with `hold`=0: return to RUN; the prescaler resumes from its frozen value.
- DONE: `remaining`=0, `flag` held at 1. Leaves DONE only on start, abort or reset. `hold` is ignored in IDLE and DONE.
- Blink mode (default):
  - `led`=0 outside warn.
  - On the cycle `warn` first asserts, `led` becomes all ones and the blink counter clears.
  - In RUN with `warn` high, `led` inverts every `BLINK_DIV` cycles.
  - In DONE, `led` is all ones, steady.
- Static checks: an elaboration-time `$error` fires if `ROUND_S` is outside 1..255, `WARN_S >= ROUND_S`, or `BLINK_DIV` < 1.

## Timing
- All outputs are registered. Nothing is combinational from inputs to outputs.
- Start latency: with `start` sampled at edge N, the values `running`=1 and `remaining`=`ROUND_S` are visible after edge N.
- First `sec_tick` occurs exactly `CLK_HZ` RUN cycles after the start edge. Ticks are `CLK_HZ` RUN cycles apart; HOLD cycles do not count.
- Full uninterrupted round: `expired` occurs `ROUND_S*CLK_HZ` cycles after the start edge.
- `warn` and `led` update in the same cycle as the `remaining` change that causes them.
- `start` and `abort` in the same cycle: abort wins.
- `start` coincident with a terminal tick: start wins; there is no `expired` and no `sec_tick`.

## Configuration
- `ROUND_TIMER_BAR_EN` defined: `led` is a thermometer bar instead of blinking.
  - Lit count = ceil(`remaining`*`LED_W`/`ROUND_S`), with bits lit from bit 0 upward.
  - The bar is shown in RUN and HOLD regardless of `warn`. `led`=0 in IDLE and DONE.
  - The blink counter is not built.
- Not defined: blink mode as described under Operation.

## Test plan
All scenarios use `CLK_HZ`=4, `ROUND_S`=5, `WARN_S`=2, `LED_W`=4, `BLINK_DIV`=2.
- Reset: hold `rst`=0 for 3 cycles, with `start` pulsed during reset -> all outputs 0, state IDLE after release.
- Full round: `start` at cycle 0 -> `sec_tick` at cycles 4, 8, 12, 16, 20. `remaining` runs 5->0. `warn` rises at cycle 12 (`remaining`=2). `expired`=1 only at cycle 20. `flag` stays 1 until the next start.
- Hold: `start` at cycle 0, `hold` high over cycles 2..11 -> first `sec_tick` at cycle 14. `running` stays 1 throughout.
- Blink: during the full round -> `led`=4'hF at cycle 12, 4'h0 at 14, 4'hF at 16, 4'h0 at 18, steady 4'hF from cycle 20.
- Restart/abort: `start` at cycle 0, `start` again at cycle 18 -> `remaining`=5, no `expired`. `start` and `abort` together -> IDLE, `remaining`=0.
- With `ROUND_TIMER_BAR_EN`: `start` -> `led`=4'hF. At `remaining`=3, `led`=4'h7 (ceil 2.4=3 lit). At `remaining`=1, `led`=4'h1. `led`=0 after `expired`.
